// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts rising edges of one selected channel over a gate window of wb_clk_i cycles.
// Latency: done rises 1+SETTLE_CYC+gate_len cycles after an accepted start; ro_mon is combinational.
// Backpressure: start is ignored while busy; the result holds in DONE until the next start (or reset). Optional macro: RO_METER_CONT_EN.
module ro_freq_meter #(
  parameter int NUM_CH     = 16,
  parameter int SEL_W      = $clog2(NUM_CH),
  parameter int GATE_W     = 16,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 3
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [NUM_CH-1:0] ro_in,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              start,
`ifdef RO_METER_CONT_EN
  input  logic              cont,
`endif
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              ro_mon
);

  // Settle counter is loaded with SETTLE_CYC-1 and counts down to zero,
  // giving exactly SETTLE_CYC cycles in SETTLE.
  localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SCNT_W-1:0] SETTLE_LOAD = SCNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_COUNT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [GATE_W-1:0]   gate_q, gate_d;
  logic [GATE_W-1:0]   gcnt_q, gcnt_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic                acc_ovf_q, acc_ovf_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                s1_q, s1_d;
  logic                s2_q, s2_d;
  logic                s3_q, s3_d;
  logic                rise;
  logic                cont_w;
  logic [CNT_W-1:0]    acc_inc;
  logic                acc_sat;

`ifdef RO_METER_CONT_EN
  assign cont_w = cont;
`else
  assign cont_w = 1'b0;
`endif

  // Raw pad copy follows the live select, not the latched one.
  assign ro_mon = ro_in[ch_sel];

  assign rise     = s2_q & ~s3_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = ovf_q;

  // Saturating increment of the window accumulator.
  always_comb begin
    acc_sat = &acc_q;
    acc_inc = acc_sat ? acc_q : acc_q + CNT_W'(1);
  end

  // Next-state logic: synchronizer chain, FSM, gate/settle counters, result capture.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    gate_d    = gate_q;
    gcnt_d    = gcnt_q;
    scnt_d    = scnt_q;
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    count_d   = count_q;
    ovf_d     = ovf_q;

    // The sync path always tracks the latched channel; SETTLE flushes it after a change.
    s1_d = ro_in[sel_q];
    s2_d = s1_q;
    s3_d = s2_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sel_d   = ch_sel;
          gate_d  = gate_len;
          count_d = '0;
          ovf_d   = 1'b0;
          scnt_d  = SETTLE_LOAD;
          state_d = S_SETTLE;
        end else if ((state_q == S_DONE) && cont_w && (gate_q != '0)) begin
          // Back-to-back window on the same channel; the sync path is already settled.
          gcnt_d    = gate_q;
          acc_d     = '0;
          acc_ovf_d = 1'b0;
          state_d   = S_COUNT;
        end
      end
      S_SETTLE: begin
        if (scnt_q != '0) begin
          scnt_d = scnt_q - SCNT_W'(1);
        end else if (gate_q == '0) begin
          state_d = S_DONE;
        end else begin
          gcnt_d    = gate_q;
          acc_d     = '0;
          acc_ovf_d = 1'b0;
          state_d   = S_COUNT;
        end
      end
      S_COUNT: begin
        gcnt_d = gcnt_q - GATE_W'(1);
        if (rise) begin
          acc_d     = acc_inc;
          acc_ovf_d = acc_ovf_q | acc_sat;
        end
        // Last sampled cycle: its edge is already folded into acc_d.
        if (gcnt_q == GATE_W'(1)) begin
          count_d = acc_d;
          ovf_d   = acc_ovf_d;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered status flags derived from the next state; busy holds through a continuous-mode DONE.
  always_comb begin
    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_SETTLE) || (state_d == S_COUNT) ||
             ((state_d == S_DONE) && (state_q == S_COUNT) && cont_w);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      gate_q    <= '0;
      gcnt_q    <= '0;
      scnt_q    <= '0;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      gate_q    <= gate_d;
      gcnt_q    <= gcnt_d;
      scnt_q    <= scnt_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
    end
  end

endmodule

// File: tb/tb_ro_freq_meter.sv
// Bench for ro_freq_meter: square-wave oscillators with distinct periods and random phases,
// expected counts from window/period arithmetic with saturation at 2^CNT_W-1.
module tb_ro_freq_meter;
  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;
  localparam int GATE_W = 16;
  localparam int CNT_W  = 8;
  localparam int SETTLE = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] ro_in;
  logic [SEL_W-1:0]  ch_sel;
  logic [GATE_W-1:0] gate_len;
  logic              start;
  logic              busy, done, overflow, ro_mon;
  logic [CNT_W-1:0]  count;
`ifdef RO_METER_CONT_EN
  logic              cont;
`endif

  int checks   = 0;
  int failures = 0;
  int per[NUM_CH];
  int ph[NUM_CH];
  int cyc = 0;

  ro_freq_meter #(
    .NUM_CH(NUM_CH), .SEL_W(SEL_W), .GATE_W(GATE_W), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .ro_in    (ro_in),
    .ch_sel   (ch_sel),
    .gate_len (gate_len),
    .start    (start),
`ifdef RO_METER_CONT_EN
    .cont     (cont),
`endif
    .busy     (busy),
    .done     (done),
    .count    (count),
    .overflow (overflow),
    .ro_mon   (ro_mon)
  );

  always #5 clk = ~clk;

  // Oscillator bank: channel i is a square wave of period per[i] cycles.
  always @(posedge clk) begin
    #2;
    cyc = cyc + 1;
    for (int i = 0; i < NUM_CH; i++)
      ro_in[i] = (((cyc + ph[i]) % per[i]) < (per[i] / 2));
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One single-shot measurement; gate must be a multiple of the channel period.
  // inj_at >= 0 pulses start with a different channel/window while busy.
  task automatic run(input int ch, input int gate, input int inj_at, input string tag);
    int edges, exp_c, exp_o, lat;
    bit busy_ok;
    edges = gate / per[ch];
    exp_c = (edges > CMAX) ? CMAX : edges;
    exp_o = (edges > CMAX) ? 1 : 0;
    ch_sel   = SEL_W'(ch);
    gate_len = GATE_W'(gate);
    start    = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_rise"}, int'(busy), 1);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < gate + 50) begin
      if (lat == inj_at) begin
        start    = 1'b1;
        ch_sel   = SEL_W'(5);
        gate_len = GATE_W'(16);
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, SETTLE + gate);
    check({tag, "_busy_held"}, int'(busy_ok), 1);
    check({tag, "_count"}, int'(count), exp_c);
    check({tag, "_overflow"}, int'(overflow), exp_o);
    check({tag, "_busy_fall"}, int'(busy), 0);
    tick();
    check({tag, "_hold"}, int'(count), exp_c);
  endtask

  initial begin
    int ch, m, lat;
    for (int i = 0; i < NUM_CH; i++) begin
      per[i] = 4 + 2 * i;
      ph[i]  = $urandom_range(0, per[i] - 1);
    end
    rst_n = 1'b0; start = 1'b0; ch_sel = '0; gate_len = '0;
`ifdef RO_METER_CONT_EN
    cont = 1'b0;
`endif

    // Reset with oscillators toggling.
    tick(); tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_count", int'(count), 0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);

    // Pad mux follows live ch_sel.
    for (int k = 0; k < 4; k++) begin
      ch_sel = SEL_W'($urandom_range(0, NUM_CH - 1));
      #1;
      check("ro_mon", int'(ro_mon), int'(ro_in[ch_sel]));
      tick();
    end

    run(2, 64, -1, "basic");
    run(2, 0, -1, "zero");
    run(0, 2048, -1, "sat");
    run(0, 16, -1, "unsat");
    run(0, 4 * 255, -1, "at_max");
    run(0, 4 * 256, -1, "past_max");
    run(2, 64, 20, "busy_ign");

    for (int r = 0; r < 5; r++) begin
      ch = $urandom_range(0, NUM_CH - 1);
      m  = $urandom_range(1, 24);
      run(ch, per[ch] * m, -1, "rand");
    end
    m = $urandom_range(254, 257);
    run(0, 4 * m, -1, "rand_edge");

    // Reset from DONE discards the held result.
    run(2, 32, -1, "pre_rst");
    rst_n = 1'b0;
    tick();
    check("rst_done_count", int'(count), 0);
    check("rst_done_done", int'(done), 0);
    rst_n = 1'b1;

    // Reset mid-COUNT.
    ch_sel = SEL_W'(2); gate_len = GATE_W'(64); start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("midcnt_busy_pre", int'(busy), 1);
    rst_n = 1'b0;
    tick();
    check("midrst_busy", int'(busy), 0);
    check("midrst_count", int'(count), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 80; k++) tick();
    check("midrst_idle_done", int'(done), 0);
    check("midrst_idle_busy", int'(busy), 0);

`ifdef RO_METER_CONT_EN
    // Continuous windows: done pulses every gate+1 cycles.
    cont = 1'b1;
    ch_sel = SEL_W'(2); gate_len = GATE_W'(32); start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin tick(); lat++; end
    check("cont_first_lat", lat, SETTLE + 32);
    check("cont_first_count", int'(count), 4);
    check("cont_first_busy", int'(busy), 1);
    for (int w = 0; w < 2; w++) begin
      tick();
      check("cont_pulse_low", int'(done), 0);
      lat = 1;
      while (!done && lat < 200) begin tick(); lat++; end
      check("cont_gap", lat, 33);
      check("cont_count", int'(count), 4);
      check("cont_busy", int'(busy), 1);
    end
    tick();
    cont = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin tick(); lat++; end
    check("cont_last_gap", lat, 33);
    check("cont_last_count", int'(count), 4);
    check("cont_park_busy", int'(busy), 0);
    tick(); tick(); tick();
    check("cont_park_done", int'(done), 1);
    check("cont_park_count", int'(count), 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ro_freq_meter.md
Name: ro_freq_meter

Overview:
- Parametrised on-chip frequency meter for a bank of ring-oscillator outputs. It replaces fixed 16:1 pad muxing with a gated edge counter.
- Selects one of NUM_CH oscillator channels and counts its rising edges over a programmable window of wb_clk_i cycles. Holds the result for readout by the management SoC via logic analyzer or GPIO.
- Still drives a raw muxed copy of the selected channel to a pad for scope observation.

Parameters:
- NUM_CH, 16, number of oscillator inputs (≥2).
- SEL_W, $clog2(NUM_CH), channel-select width.
- GATE_W, 16, gate-window length width, in wb_clk_i cycles.
- CNT_W, 16, edge-count result width.
- SETTLE_CYC, 3, synchronizer flush cycles after channel latch (≥3).

Ports:
- wb_clk_i  in  1  system clock; sole clock of the block.
- wb_rst_ni  in  1  reset, synchronous, active-low.
- ro_in  in  NUM_CH  oscillator outputs, externally prescaled to < f(wb_clk_i)/4.
- ch_sel  in  SEL_W  channel to measure; sampled on accepted start.
- gate_len  in  GATE_W  window length; sampled on accepted start.
- start  in  1  one-cycle request pulse.
- busy  out  1  high in SETTLE and COUNT.
- done  out  1  high in DONE; result valid.
- count  out  CNT_W  rising edges counted in the last window.
- overflow  out  1  count saturated in the last window.
- ro_mon  out  1  combinational ro_in[ch_sel] (live ch_sel, unregistered), for pad.

Behaviour:
- Reset (wb_rst_ni=0 at a clock edge):
  - State goes to IDLE.
  - busy, done, count, overflow, synchronizer and edge flops, and internal counters all clear to 0.
  - Reset dominates every other event, including mid-COUNT; the partial count is discarded.
- Input path:
  - ro_in[sel_q] passes through a 2-flop synchronizer (s1, s2), then an edge flop s3.
  - Rising edge = s2 & ~s3.
  - sel_q is the latched channel; the sync path always follows sel_q.
- FSM:
  - IDLE: start=1 → latch sel_q=ch_sel and gate_q=gate_len; clear count/overflow; go to SETTLE.
  - DONE: behaves like IDLE on start; otherwise holds.
  - SETTLE: runs SETTLE_CYC cycles with no counting. Then go to COUNT if gate_q≠0; if gate_q=0, go directly to DONE with count=0.
  - COUNT: gate counter loads gate_q and decrements every cycle. An edge seen in a cycle increments count. After exactly gate_q sampled cycles, go to DONE.
- Timing: busy rises the cycle after start and falls as done rises. done rises at cycle 1+SETTLE_CYC+gate_len after start.
- start while busy: ignored. ch_sel/gate_len changes while busy: ignored.
- Saturation: count never wraps. On an increment at all-ones it holds at 2^CNT_W−1 and sets overflow (sticky until the next accepted start).
- count and overflow remain stable throughout DONE.
- Edge in the final COUNT cycle: included. Edge in the first DONE cycle: excluded.

Optional Feature:
- Macro RO_METER_CONT_EN.
- Defined:
  - Adds input port cont (1 bit).
  - In DONE with cont=1 and no start, the FSM re-enters COUNT on the next cycle with the same sel_q/gate_q and no SETTLE. The internal accumulator restarts from 0.
  - The count output updates only at each window end. done becomes a one-cycle pulse per window; busy stays high.
  - start in DONE takes priority over cont.
  - cont=0 while busy: the current window completes, then the FSM parks in DONE.
- Undefined: no cont port; single-shot only.

Test Plan:
1. Reset: hold wb_rst_ni=0 for 2 cycles with ro_in toggling → busy=done=overflow=0, count=0; FSM stays IDLE after release.
2. Basic measurement: ro_in[2] square wave, period 8 cycles; ch_sel=2, gate_len=64; pulse start at cycle 0 → busy=1 at cycle 1, done=1 at cycle 68, count=8, overflow=0.
3. Zero window: gate_len=0, start → done at cycle 4, count=0, overflow=0.
4. Saturation: CNT_W=8, ro_in[0] period 4, gate_len=2048 → count=255, overflow=1. A new start with gate_len=16 → count=4, overflow=0.
5. Busy robustness: during COUNT, pulse start and change ch_sel 2→5 → both ignored, count=8 as in scenario 2. Assert wb_rst_ni=0 mid-COUNT → next cycle IDLE, count=0, busy=0.
6. RO_METER_CONT_EN build: cont=1, period 8, gate_len=32 → done pulses every 33 cycles, count=4 each window. Drop cont → parks in DONE after the current window.
